// File: rtl/bit_pattern_tx_pkg.sv
// bit_pattern_tx_pkg: shared types and constants for the bit-pattern transmitter.
//   state_t    : transmitter FSM states (idle, shifting bits, inter-frame gap, done pulse)
//   GAP_CNT_W  : width of the inter-frame gap counter (GAP legal range is 1..15)
package bit_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/bit_pattern_tx_rise_detect.sv
// rise_detect: rising-edge detector for a level input (e.g. an inverted pushbutton).
//   clk   : clock
//   reset : asynchronous active-high reset
//   in    : level input
//   rise  : high in the cycle where in=1 and the previous sample was 0
// After reset the detector stays disarmed until in has been seen low once, so a
// button held through reset release does not fire until it is released and pressed.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;
    logic armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= in;
            if (!in)
                armed <= 1'b1;
        end
    end

    assign rise = in & ~prev & armed;

endmodule

// File: rtl/bit_pattern_tx.sv
// bit_pattern_tx: serialises a latched pattern MSB-first onto w, optionally
// repeating it with GAP idle-low cycles between frames.
//   clk       : clock
//   reset     : asynchronous active-high reset
//   start     : level request, only its rising edge starts a frame (from IDLE)
//   pattern   : frame bits, sent from pattern[len] down to pattern[0]
//   len       : frame length minus 1 (values >= WIDTH behave as WIDTH-1)
//   repeat_en : sampled at frame end; high resends the frame after a gap
//   abort     : synchronous cancel, highest priority
//   w         : registered serial output
//   busy      : high in SHIFT and GAP
//   done      : one-cycle pulse when a frame ends without repeating
//   bit_idx   : index of the bit currently on w, 0 when not shifting
module bit_pattern_tx
    import bit_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH)-1:0]   len,
    input  logic                       repeat_en,
    input  logic                       abort,
    output logic                       w,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_idx
);

    localparam int IW = $clog2(WIDTH);

    state_t               state;
    logic [WIDTH-1:0]     shadow_pat;
    logic [IW-1:0]        shadow_len;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [IW-1:0]        len_eff;
    logic                 rise;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .in    (start),
        .rise  (rise)
    );

    // Clamping only matters when WIDTH is not a power of two; otherwise every
    // encodable len is already in range.
    generate
        if ((1 << IW) > WIDTH) begin : g_clamp
            assign len_eff = (int'(len) >= WIDTH) ? IW'(WIDTH - 1) : len;
        end else begin : g_noclamp
            assign len_eff = len;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            w          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_idx    <= '0;
            shadow_pat <= '0;
            shadow_len <= '0;
            gap_cnt    <= '0;
        end else if (abort) begin
            state   <= ST_IDLE;
            w       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        // first bit comes straight from the input; shadow is
                        // being loaded on this same edge
                        shadow_pat <= pattern;
                        shadow_len <= len_eff;
                        w          <= pattern[len_eff];
                        bit_idx    <= len_eff;
                        busy       <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        w       <= shadow_pat[bit_idx - 1'b1];
                    end else if (repeat_en) begin
                        w       <= 1'b0;
                        gap_cnt <= GAP_CNT_W'(GAP - 1);
                        state   <= ST_GAP;
                    end else begin
                        w     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        w       <= shadow_pat[shadow_len];
                        bit_idx <= shadow_len;
                        state   <= ST_SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_pattern_tx.sv
// tb_bit_pattern_tx: scoreboard bench for bit_pattern_tx. Stimulus pushes the
// expected per-cycle outputs (w, busy, done, bit_idx); a monitor pops one entry
// 1 time unit after every posedge while entries are pending.
module tb_bit_pattern_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [2:0] len;
    logic       repeat_en;
    logic       abort;
    logic       w;
    logic       busy;
    logic       done;
    logic [2:0] bit_idx;

    typedef struct {
        logic       w;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .repeat_en (repeat_en),
        .abort     (abort),
        .w         (w),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic wv, input logic b, input logic d, input logic [2:0] i);
        exp_t x;
        x = '{wv, b, d, i};
        q.push_back(x);
    endtask

    // frame bits from index hi down to lo, MSB first
    task automatic push_bits(input logic [7:0] p, input int hi, input int lo);
        for (int i = hi; i >= lo; i--)
            push(p[i], 1'b1, 1'b0, i[2:0]);
    endtask

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic push_done();
        push(1'b0, 1'b0, 1'b1, 3'd0);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("w",       w,       e.w);
            chk("busy",    busy,    e.busy);
            chk("done",    done,    e.done);
            chk("bit_idx", bit_idx, e.idx);
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; repeat_en = 1'b0; abort = 1'b0;
        pattern = 8'h00; len = 3'd0;
        #1;
        chk("rst_w",    w,       0);
        chk("rst_busy", busy,    0);
        chk("rst_done", done,    0);
        chk("rst_idx",  bit_idx, 0);
        push_idle(3);
        @(negedge clk); reset = 1'b0;
        wait_drain();

        // single frame 0B, len 3 -> 1,0,1,1 then done
        pattern = 8'h0B; len = 3'd3; repeat_en = 1'b0; start = 1'b1;
        push_bits(8'h0B, 3, 0); push_done(); push_idle(2);
        @(negedge clk); start = 1'b0;
        wait_drain();

        // repeat mode A5, pattern/len changes after latch are ignored,
        // repeat_en dropped during the second frame
        pattern = 8'hA5; len = 3'd7; repeat_en = 1'b1; start = 1'b1;
        push_bits(8'hA5, 7, 0); push_gap(GAP); push_bits(8'hA5, 7, 0);
        push_done(); push_idle(2);
        @(negedge clk); start = 1'b0; pattern = 8'h3C; len = 3'd2;
        repeat (12) @(negedge clk);
        repeat_en = 1'b0;
        wait_drain();

        // start held high, plus a second rise while busy -> one frame only
        pattern = 8'h0B; len = 3'd3; start = 1'b1;
        push_bits(8'h0B, 3, 0); push_done(); push_idle(22);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // abort while bit_idx=2 -> idle next cycle, no done
        pattern = 8'hA5; len = 3'd7; start = 1'b1;
        push_bits(8'hA5, 7, 2); push_idle(4);
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_drain();

        // abort wins over a simultaneous start rise
        start = 1'b1; abort = 1'b1;
        push_idle(4);
        @(negedge clk); abort = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // len=0 single-bit frame
        pattern = 8'h01; len = 3'd0; start = 1'b1;
        push_bits(8'h01, 0, 0); push_done(); push_idle(2);
        @(negedge clk); start = 1'b0;
        wait_drain();

        // asynchronous reset mid-frame, start held through release
        pattern = 8'h0B; len = 3'd3; start = 1'b1;
        push_bits(8'h0B, 3, 2);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("arst_w",    w,       0);
        chk("arst_busy", busy,    0);
        chk("arst_done", done,    0);
        chk("arst_idx",  bit_idx, 0);
        push_idle(5);
        @(negedge clk); reset = 1'b0;
        wait_drain();
        start = 1'b0;
        @(negedge clk); start = 1'b1;
        push_bits(8'h0B, 3, 0); push_done(); push_idle(2);
        @(negedge clk); start = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
